// File: rtl/hash_soc_bridge.sv
// Bus-side bridge for an Ascon hash core: buffers a message in BW-bit words,
// launches the core, then streams the captured digest back one word per read.
module hash_soc_bridge #(
  parameter int BW = 8,
  parameter int Y  = 256,
  parameter int L  = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       reg_inputxSS,
  input  logic [BW-1:0]              messagexSI,
  input  logic                       clearxSI,
  input  logic                       reg_startxSS,
  input  logic                       hash_startxSI,
  input  logic                       reg_outxSS,
  output logic [BW-1:0]              hash_digestxSO,
  output logic                       hash_readyxSO,
  output logic                       busyxSO,
  output logic                       overflowxSO,
  output logic [$clog2(Y/8+1)-1:0]   msg_lenxSO,
  output logic [Y-1:0]               core_messagexSO,
  output logic [$clog2(Y/8+1)-1:0]   core_lenxSO,
  output logic                       core_startxSO,
  input  logic                       core_donexSI,
  input  logic [L-1:0]               core_digestxSI
);

  localparam int LW = $clog2(Y/8+1);
  localparam int NB = BW/8;
  localparam int YB = Y/8;
  localparam int NR = L/BW;
  localparam int RW = $clog2(NR+1);
  localparam logic [LW:0] NB_EXT = (LW+1)'(NB);
  localparam logic [LW:0] YB_EXT = (LW+1)'(YB);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [Y-1:0]    buf_q, buf_d;
  logic [LW-1:0]   len_q, len_d;
  logic [L-1:0]    dig_q, dig_d;
  logic            ovf_q, ovf_d;
  logic [RW-1:0]   rcnt_q, rcnt_d;

  logic            start_req_s;
  logic            wr_fits_s;
  logic            last_rd_s;

  // Place a bus word at byte offset len, first byte in the word's MSBs.
  function automatic logic [Y-1:0] put_word(input logic [Y-1:0] b,
                                            input logic [LW-1:0] len,
                                            input logic [BW-1:0] w);
    logic [Y-1:0] r;
    r = b;
    for (int i = 0; i < YB; i++) begin
      for (int j = 0; j < NB; j++) begin
        if (i == int'(len) + j) begin
          r[Y-1-8*i -: 8] = w[BW-1-8*j -: 8];
        end else begin
          r[Y-1-8*i -: 8] = r[Y-1-8*i -: 8];
        end
      end
    end
    return r;
  endfunction

  assign start_req_s = reg_startxSS & hash_startxSI;
  assign wr_fits_s   = ({1'b0, len_q} + NB_EXT) <= YB_EXT;
  assign last_rd_s   = (rcnt_q == RW'(NR-1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; clear overrides every other input.
  always_comb begin
    state_d = state_q;
    if (clearxSI) begin
      state_d = S_LOAD;
    end else begin
      case (state_q)
        S_LOAD:  state_d = start_req_s ? S_START : S_LOAD;
        S_START: state_d = S_WAIT;
        S_WAIT:  state_d = core_donexSI ? S_OUT : S_WAIT;
        S_OUT:   state_d = (reg_outxSS && last_rd_s) ? S_LOAD : S_OUT;
        default: state_d = S_LOAD;
      endcase
    end
  end

  // Datapath next-state: message buffer, length, digest shifter, overflow.
  always_comb begin
    buf_d  = buf_q;
    len_d  = len_q;
    dig_d  = dig_q;
    ovf_d  = ovf_q;
    rcnt_d = rcnt_q;
    if (clearxSI) begin
      buf_d  = {Y{1'b0}};
      len_d  = {LW{1'b0}};
      dig_d  = {L{1'b0}};
      ovf_d  = 1'b0;
      rcnt_d = {RW{1'b0}};
    end else begin
      case (state_q)
        S_LOAD: begin
          if (reg_inputxSS && wr_fits_s) begin
            buf_d = put_word(buf_q, len_q, messagexSI);
            len_d = len_q + LW'(NB);
          end else if (reg_inputxSS) begin
            ovf_d = 1'b1;
          end else begin
            buf_d = buf_q;
          end
        end
        S_WAIT: begin
          if (core_donexSI) begin
            dig_d  = core_digestxSI;
            rcnt_d = {RW{1'b0}};
          end else begin
            dig_d  = dig_q;
          end
        end
        S_OUT: begin
          if (reg_outxSS && last_rd_s) begin
            dig_d  = {L{1'b0}};
            buf_d  = {Y{1'b0}};
            len_d  = {LW{1'b0}};
            ovf_d  = 1'b0;
            rcnt_d = {RW{1'b0}};
          end else if (reg_outxSS) begin
            dig_d  = dig_q << BW;
            rcnt_d = rcnt_q + RW'(1);
          end else begin
            dig_d  = dig_q;
          end
        end
        default: begin
          buf_d = buf_q;
        end
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q  <= {Y{1'b0}};
      len_q  <= {LW{1'b0}};
      dig_q  <= {L{1'b0}};
      ovf_q  <= 1'b0;
      rcnt_q <= {RW{1'b0}};
    end else begin
      buf_q  <= buf_d;
      len_q  <= len_d;
      dig_q  <= dig_d;
      ovf_q  <= ovf_d;
      rcnt_q <= rcnt_d;
    end
  end

  // Outputs decoded from registered state only; no input reaches an output.
  always_comb begin
    hash_digestxSO  = (state_q == S_OUT) ? dig_q[L-1 -: BW] : {BW{1'b0}};
    hash_readyxSO   = (state_q == S_OUT);
    busyxSO         = (state_q == S_START) || (state_q == S_WAIT);
    core_startxSO   = (state_q == S_START);
    overflowxSO     = ovf_q;
    msg_lenxSO      = len_q;
    core_lenxSO     = len_q;
    core_messagexSO = buf_q;
  end

endmodule
